membus_arbiter: RTL and testbench
=================================

# membus_arbiter

Two-to-one Membus arbiter between the core's instruction-fetch port and its load/store port, driving the single request port of the MMIO controller. It allows at most one outstanding request and routes each response back to the master that issued it. Under contention it alternates grants so that neither master starves. It adds no latency on either the request path or the response path.

## Interface
- IBUS_FIRST, 0: when both masters contend and no grant history exists (after reset), 1 grants ibus first, 0 grants dbus first.
- clk  in  1  single clock for the block.
- rst  in  1  one clock; reset is synchronous and active-high.
- ibus  Membus.slave  XLEN addr / MEMBUS_DATA_WIDTH data / MEMBUS_DATA_WIDTH/8 wmask  instruction-fetch requester.
- dbus  Membus.slave  same widths  load/store requester.
- mem  Membus.master  same widths  toward the MMIO controller's core-side slave.

## Operation
- State: `owner` (NONE/IBUS/DBUS) of the outstanding request; `lock` (NONE/IBUS/DBUS) for a presented but unaccepted request; `last_grant` (IBUS/DBUS) for fairness.
- Selection, computed each cycle:
  - If `lock` is not NONE, select the locked master.
  - Otherwise, if only one master has valid=1, select it.
  - Otherwise, if both have valid=1, select the master that is not `last_grant`. After reset the pick follows IBUS_FIRST.
- Issue eligibility: `owner`==NONE, or the outstanding response completes this cycle (mem.rvalid=1).
- When eligible:
  - mem.valid/addr/wen/wdata/wmask equal the selected master's fields.
  - The selected master's ready equals mem.ready.
  - The other master's ready is 0.
- When not eligible: mem.valid=0 and both readies are 0.
- Accept = mem.valid & mem.ready. On accept: `owner`←selected master, `last_grant`←selected master, `lock`←NONE.
- Present without accept (mem.valid=1, mem.ready=0): `lock`←selected master. The downstream request stays stable until accepted.
- Response routing:
  - owner.rvalid=mem.rvalid and owner.rdata=mem.rdata.
  - The non-owner gets rvalid=0 and rdata=0.
  - When `owner`==NONE, both get rvalid=0.
- On mem.rvalid=1 with no new accept in the same cycle: `owner`←NONE.
- mem.rvalid=1 while `owner`==NONE: the response is dropped, no state change, and it is flagged by a simulation-only assertion.
- A master dropping valid before acceptance is a protocol violation. If `lock` points to it, the arbiter clears `lock` next cycle and re-arbitrates.

## Timing
- Reset (rst=1 at a clk edge): `owner`=NONE, `lock`=NONE, `last_grant`=DBUS if IBUS_FIRST=1, else IBUS.
- While rst=1, all outputs are forced to 0: mem.valid/addr/wen/wdata/wmask, ibus/dbus ready/rvalid/rdata.
- Request path is combinational: a master's valid reaches mem.valid in the same cycle, with zero added cycles.
- Response path is combinational: mem.rvalid/rdata reach the owner in the same cycle.
- Back-to-back: in the cycle mem.rvalid=1, a new request may be accepted. Sustained throughput is one transaction per downstream round-trip.
- Contention with both masters continuously valid: grants alternate I,D,I,D… (IBUS_FIRST=1).
- Reset asserted with a request outstanding:
  - State is cleared.
  - A late mem.rvalid after reset is treated as stray (dropped).
  - The surrounding reset also resets the MMIO controller.

## Test plan
- Single ibus read, addr 0x8000_0000, downstream ready=1, rvalid 1 cycle later with rdata 0x0000_0013 -> mem.valid same cycle as ibus.valid; ibus.rvalid/rdata=0x13 the next cycle; dbus.rvalid stays 0.
- Both valid continuously, IBUS_FIRST=1, downstream round-trip of 2 cycles -> mem accepts addresses in order ibus, dbus, ibus, dbus; each rdata returns only to its issuer.
- dbus write (wen=1, wmask=0x0F, wdata=0xDEAD_BEEF), mem.ready=0 for 3 cycles while ibus raises valid -> mem fields hold the dbus request unchanged; ibus.ready=0 throughout; dbus is accepted when ready=1.
- Back-to-back: rvalid for request A in the same cycle as ibus valid -> the new request is accepted that cycle; `owner` switches without an idle cycle.
- Stray mem.rvalid=1 with no outstanding request -> both rvalid stay 0; state unchanged; assertion fires.
- rst=1 mid-transaction (`owner`=DBUS) -> all outputs are 0 during reset; after release, the first contended grant follows IBUS_FIRST.

Source files
------------

// File: rtl/membus_arbiter.sv
// Two-to-one Membus arbiter (instruction fetch vs. load/store) in front of the MMIO controller.
// One outstanding request, zero added latency, alternating grants under contention.
module membus_arbiter #(
  parameter int XLEN              = 32,
  parameter int MEMBUS_DATA_WIDTH = 32,
  parameter bit IBUS_FIRST        = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  // instruction-fetch requester
  input  logic                           ibus_valid_i,
  output logic                           ibus_ready_o,
  input  logic [XLEN-1:0]                ibus_addr_i,
  input  logic                           ibus_wen_i,
  input  logic [MEMBUS_DATA_WIDTH-1:0]   ibus_wdata_i,
  input  logic [MEMBUS_DATA_WIDTH/8-1:0] ibus_wmask_i,
  output logic                           ibus_rvalid_o,
  output logic [MEMBUS_DATA_WIDTH-1:0]   ibus_rdata_o,
  // load/store requester
  input  logic                           dbus_valid_i,
  output logic                           dbus_ready_o,
  input  logic [XLEN-1:0]                dbus_addr_i,
  input  logic                           dbus_wen_i,
  input  logic [MEMBUS_DATA_WIDTH-1:0]   dbus_wdata_i,
  input  logic [MEMBUS_DATA_WIDTH/8-1:0] dbus_wmask_i,
  output logic                           dbus_rvalid_o,
  output logic [MEMBUS_DATA_WIDTH-1:0]   dbus_rdata_o,
  // toward the MMIO controller
  output logic                           mem_valid_o,
  input  logic                           mem_ready_i,
  output logic [XLEN-1:0]                mem_addr_o,
  output logic                           mem_wen_o,
  output logic [MEMBUS_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [MEMBUS_DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                           mem_rvalid_i,
  input  logic [MEMBUS_DATA_WIDTH-1:0]   mem_rdata_i,
  // state observation: 0=NONE, 1=IBUS, 2=DBUS
  output logic [1:0]                     dbg_owner_o,
  output logic [1:0]                     dbg_lock_o,
  output logic [1:0]                     dbg_last_grant_o,
  output logic                           dbg_stray_o
);

  // Handshake: a request transfers when valid & ready are both high at a clk edge;
  // a master holds its request fields stable while valid is high and ready is low.

  localparam int DW = MEMBUS_DATA_WIDTH;
  localparam int MW = MEMBUS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    M_NONE = 2'd0,
    M_IBUS = 2'd1,
    M_DBUS = 2'd2
  } master_e;

  localparam master_e LAST_GRANT_RST = IBUS_FIRST ? M_DBUS : M_IBUS;

  master_e owner_q, owner_d;
  master_e lock_q, lock_d;
  master_e last_grant_q, last_grant_d;

  master_e         sel;
  logic            eligible;
  logic            sel_valid;
  logic [XLEN-1:0] sel_addr;
  logic            sel_wen;
  logic [DW-1:0]   sel_wdata;
  logic [MW-1:0]   sel_wmask;
  logic            req_valid;
  logic            accept;
  logic            stray;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= M_NONE;
      lock_q       <= M_NONE;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Selection: a pending (locked) request wins, then a lone requester, then fairness.
  always_comb begin
    sel = M_NONE;
    if (lock_q != M_NONE) begin
      sel = lock_q;
    end else if (ibus_valid_i && dbus_valid_i) begin
      sel = (last_grant_q == M_IBUS) ? M_DBUS : M_IBUS;
    end else if (ibus_valid_i) begin
      sel = M_IBUS;
    end else if (dbus_valid_i) begin
      sel = M_DBUS;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_wen   = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    case (sel)
      M_IBUS: begin
        sel_valid = ibus_valid_i;
        sel_addr  = ibus_addr_i;
        sel_wen   = ibus_wen_i;
        sel_wdata = ibus_wdata_i;
        sel_wmask = ibus_wmask_i;
      end
      M_DBUS: begin
        sel_valid = dbus_valid_i;
        sel_addr  = dbus_addr_i;
        sel_wen   = dbus_wen_i;
        sel_wdata = dbus_wdata_i;
        sel_wmask = dbus_wmask_i;
      end
      default: ;
    endcase
  end

  // A completing response frees the slot in the same cycle, enabling back-to-back issue.
  assign eligible  = (owner_q == M_NONE) || mem_rvalid_i;
  assign req_valid = eligible && sel_valid;
  assign accept    = req_valid && mem_ready_i;
  assign stray     = mem_rvalid_i && (owner_q == M_NONE);

  always_comb begin
    owner_d      = owner_q;
    lock_d       = M_NONE;
    last_grant_d = last_grant_q;
    if (accept) begin
      owner_d      = sel;
      last_grant_d = sel;
    end else begin
      if (req_valid) begin
        lock_d = sel;
      end
      if (mem_rvalid_i) begin
        owner_d = M_NONE;
      end
    end
  end

  always_comb begin
    mem_valid_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wen_o     = 1'b0;
    mem_wdata_o   = '0;
    mem_wmask_o   = '0;
    ibus_ready_o  = 1'b0;
    dbus_ready_o  = 1'b0;
    ibus_rvalid_o = 1'b0;
    ibus_rdata_o  = '0;
    dbus_rvalid_o = 1'b0;
    dbus_rdata_o  = '0;
    if (!rst) begin
      if (eligible) begin
        mem_valid_o  = sel_valid;
        mem_addr_o   = sel_addr;
        mem_wen_o    = sel_wen;
        mem_wdata_o  = sel_wdata;
        mem_wmask_o  = sel_wmask;
        ibus_ready_o = (sel == M_IBUS) && mem_ready_i;
        dbus_ready_o = (sel == M_DBUS) && mem_ready_i;
      end
      if (owner_q == M_IBUS) begin
        ibus_rvalid_o = mem_rvalid_i;
        ibus_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
      end
      if (owner_q == M_DBUS) begin
        dbus_rvalid_o = mem_rvalid_i;
        dbus_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
      end
    end
  end

  assign dbg_owner_o      = owner_q;
  assign dbg_lock_o       = lock_q;
  assign dbg_last_grant_o = last_grant_q;
  assign dbg_stray_o      = stray && !rst;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!stray) else $warning("membus_arbiter: response with no outstanding request dropped");
    end
  end
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: reset, single read, contention, stall/lock,
// back-to-back, stray response and reset mid-transaction.
module tb_membus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_valid, ibus_ready, ibus_wen, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_wdata, ibus_rdata;
  logic [3:0]  ibus_wmask;
  logic        dbus_valid, dbus_ready, dbus_wen, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  dbg_owner, dbg_lock, dbg_last_grant;
  logic        dbg_stray;

  int checks = 0;
  int errors = 0;

  membus_arbiter #(.XLEN(32), .MEMBUS_DATA_WIDTH(32), .IBUS_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ibus_valid_i(ibus_valid), .ibus_ready_o(ibus_ready), .ibus_addr_i(ibus_addr),
    .ibus_wen_i(ibus_wen), .ibus_wdata_i(ibus_wdata), .ibus_wmask_i(ibus_wmask),
    .ibus_rvalid_o(ibus_rvalid), .ibus_rdata_o(ibus_rdata),
    .dbus_valid_i(dbus_valid), .dbus_ready_o(dbus_ready), .dbus_addr_i(dbus_addr),
    .dbus_wen_i(dbus_wen), .dbus_wdata_i(dbus_wdata), .dbus_wmask_i(dbus_wmask),
    .dbus_rvalid_o(dbus_rvalid), .dbus_rdata_o(dbus_rdata),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .dbg_owner_o(dbg_owner), .dbg_lock_o(dbg_lock), .dbg_last_grant_o(dbg_last_grant),
    .dbg_stray_o(dbg_stray)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ibus(input logic v, input logic [31:0] a);
    ibus_valid = v; ibus_addr = a; ibus_wen = 1'b0; ibus_wdata = '0; ibus_wmask = '0;
  endtask

  task automatic set_dbus(input logic v, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] m);
    dbus_valid = v; dbus_addr = a; dbus_wen = w; dbus_wdata = d; dbus_wmask = m;
  endtask

  task automatic set_mem(input logic rdy, input logic rv, input logic [31:0] rd);
    mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_ibus(1'b1, 32'h1234_5678);
    set_dbus(1'b1, 32'h8765_4321, 1'b1, 32'hFFFF_FFFF, 4'hF);
    set_mem(1'b1, 1'b1, 32'hCAFE_F00D);
    next_cycle();
    next_cycle();
    checks++;
    if ({mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_mem_outputs: got valid=%b addr=%h wen=%b wdata=%h wmask=%h, want all 0",
               mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
    end
    checks++;
    if ({ibus_ready, ibus_rvalid, ibus_rdata, dbus_ready, dbus_rvalid, dbus_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_master_outputs: got iready=%b irv=%b ird=%h dready=%b drv=%b drd=%h, want all 0",
               ibus_ready, ibus_rvalid, ibus_rdata, dbus_ready, dbus_rvalid, dbus_rdata);
    end
    checks++;
    if ({dbg_owner, dbg_lock, dbg_last_grant} !== 6'b00_00_10) begin
      errors++;
      $display("FAIL reset_state: got owner=%0d lock=%0d last=%0d, want 0 0 2",
               dbg_owner, dbg_lock, dbg_last_grant);
    end
    rst = 1'b0;
    set_ibus(1'b0, '0);
    set_dbus(1'b0, '0, 1'b0, '0, '0);
    set_mem(1'b0, 1'b0, '0);
  endtask

  task automatic test_single_read();
    next_cycle();
    set_ibus(1'b1, 32'h8000_0000);
    set_mem(1'b1, 1'b0, '0);
    #1;
    checks++;
    if ({mem_valid, mem_addr, ibus_ready, dbus_ready} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_req: got valid=%b addr=%h iready=%b dready=%b, want 1 80000000 1 0",
               mem_valid, mem_addr, ibus_ready, dbus_ready);
    end
    next_cycle();
    set_ibus(1'b0, '0);
    set_mem(1'b1, 1'b1, 32'h0000_0013);
    #1;
    checks++;
    if ({ibus_rvalid, ibus_rdata, dbus_rvalid, dbus_rdata, mem_valid} !== {1'b1, 32'h13, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL single_resp: got irv=%b ird=%h drv=%b drd=%h mvalid=%b, want 1 00000013 0 0 0",
               ibus_rvalid, ibus_rdata, dbus_rvalid, dbus_rdata, mem_valid);
    end
    next_cycle();
    set_mem(1'b1, 1'b0, '0);
    #1;
    checks++;
    if ({dbg_owner, dbg_last_grant} !== 4'b00_01) begin
      errors++;
      $display("FAIL single_state: got owner=%0d last=%0d, want 0 1", dbg_owner, dbg_last_grant);
    end
  endtask

  // Both masters valid, two-cycle round trip: grants must go I, D, I, D.
  task automatic test_contention();
    logic [31:0] want_addr;
    logic        want_i;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_ibus(1'b1, 32'h0000_0100);
    set_dbus(1'b1, 32'h0000_0200, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      set_mem(1'b1, (k > 0), 32'hA0 + k);
      #1;
      want_i    = (k % 2 == 0);
      want_addr = want_i ? 32'h100 : 32'h200;
      checks++;
      if ({mem_valid, mem_addr, ibus_ready, dbus_ready} !== {1'b1, want_addr, want_i, ~want_i}) begin
        errors++;
        $display("FAIL contention_grant%0d: got valid=%b addr=%h iready=%b dready=%b, want 1 %h %b %b",
                 k, mem_valid, mem_addr, ibus_ready, dbus_ready, want_addr, want_i, ~want_i);
      end
      if (k > 0) begin
        checks++;
        if ({ibus_rvalid, dbus_rvalid, ibus_rdata | dbus_rdata} !== {~want_i, want_i, 32'hA0 + k}) begin
          errors++;
          $display("FAIL contention_resp%0d: got irv=%b drv=%b ird=%h drd=%h, want irv=%b drv=%b data=%h",
                   k, ibus_rvalid, dbus_rvalid, ibus_rdata, dbus_rdata, ~want_i, want_i, 32'hA0 + k);
        end
      end
      next_cycle();
      set_mem(1'b1, 1'b0, '0);
      #1;
      checks++;
      if ({mem_valid, ibus_ready, dbus_ready} !== 3'b000) begin
        errors++;
        $display("FAIL contention_wait%0d: got valid=%b iready=%b dready=%b, want 0 0 0",
                 k, mem_valid, ibus_ready, dbus_ready);
      end
      next_cycle();
    end
    set_ibus(1'b0, '0);
    set_dbus(1'b0, '0, 1'b0, '0, '0);
    set_mem(1'b1, 1'b1, 32'hA4);
    #1;
    checks++;
    if ({ibus_rvalid, dbus_rvalid, dbus_rdata} !== {1'b0, 1'b1, 32'hA4}) begin
      errors++;
      $display("FAIL contention_last_resp: got irv=%b drv=%b drd=%h, want 0 1 000000a4",
               ibus_rvalid, dbus_rvalid, dbus_rdata);
    end
  endtask

  // Stalled dbus write must hold the downstream request while ibus waits;
  // then ibus is issued in the same cycle the dbus response returns.
  task automatic test_stall_and_back_to_back();
    next_cycle();
    set_dbus(1'b1, 32'h0000_0300, 1'b1, 32'hDEAD_BEEF, 4'h0F);
    set_mem(1'b0, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) set_ibus(1'b1, 32'h0000_0400);
      #1;
      checks++;
      if ({mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ibus_ready, dbus_ready} !==
          {1'b1, 32'h300, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b addr=%h wen=%b wdata=%h wmask=%h iready=%b dready=%b",
                 c, mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ibus_ready, dbus_ready);
      end
      next_cycle();
    end
    set_mem(1'b1, 1'b0, '0);
    #1;
    checks++;
    if ({mem_valid, mem_addr, dbus_ready, ibus_ready} !== {1'b1, 32'h300, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stall_accept: got valid=%b addr=%h dready=%b iready=%b, want 1 00000300 1 0",
               mem_valid, mem_addr, dbus_ready, ibus_ready);
    end
    next_cycle();
    set_dbus(1'b0, '0, 1'b0, '0, '0);
    #1;
    checks++;
    if ({mem_valid, ibus_ready, dbg_owner} !== {1'b0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL b2b_wait: got valid=%b iready=%b owner=%0d, want 0 0 2", mem_valid, ibus_ready, dbg_owner);
    end
    next_cycle();
    set_mem(1'b1, 1'b1, 32'h55);
    #1;
    checks++;
    if ({dbus_rvalid, dbus_rdata, mem_valid, mem_addr, ibus_ready} !== {1'b1, 32'h55, 1'b1, 32'h400, 1'b1}) begin
      errors++;
      $display("FAIL b2b_issue: got drv=%b drd=%h valid=%b addr=%h iready=%b, want 1 00000055 1 00000400 1",
               dbus_rvalid, dbus_rdata, mem_valid, mem_addr, ibus_ready);
    end
    next_cycle();
    set_ibus(1'b0, '0);
    set_mem(1'b1, 1'b1, 32'h66);
    #1;
    checks++;
    if ({dbg_owner, ibus_rvalid, ibus_rdata, dbus_rvalid} !== {2'd1, 1'b1, 32'h66, 1'b0}) begin
      errors++;
      $display("FAIL b2b_resp: got owner=%0d irv=%b ird=%h drv=%b, want 1 1 00000066 0",
               dbg_owner, ibus_rvalid, ibus_rdata, dbus_rvalid);
    end
  endtask

  task automatic test_stray();
    next_cycle();
    set_mem(1'b1, 1'b0, '0);
    next_cycle();
    set_mem(1'b1, 1'b1, 32'h77);
    #1;
    checks++;
    if ({ibus_rvalid, dbus_rvalid, ibus_rdata, dbus_rdata, dbg_stray} !== {1'b0, 1'b0, 64'h0, 1'b1}) begin
      errors++;
      $display("FAIL stray_drop: got irv=%b drv=%b ird=%h drd=%h stray=%b, want 0 0 0 0 1",
               ibus_rvalid, dbus_rvalid, ibus_rdata, dbus_rdata, dbg_stray);
    end
    next_cycle();
    set_mem(1'b1, 1'b0, '0);
    #1;
    checks++;
    if ({dbg_owner, dbg_lock, dbg_last_grant} !== 6'b00_00_01) begin
      errors++;
      $display("FAIL stray_state: got owner=%0d lock=%0d last=%0d, want 0 0 1",
               dbg_owner, dbg_lock, dbg_last_grant);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    set_dbus(1'b1, 32'h0000_0500, 1'b0, '0, '0);
    set_mem(1'b1, 1'b0, '0);
    next_cycle();
    set_dbus(1'b0, '0, 1'b0, '0, '0);
    #1;
    checks++;
    if (dbg_owner !== 2'd2) begin
      errors++;
      $display("FAIL mid_owner: got owner=%0d, want 2", dbg_owner);
    end
    next_cycle();
    rst = 1'b1;
    set_ibus(1'b1, 32'h0000_0600);
    set_dbus(1'b1, 32'h0000_0700, 1'b1, 32'h1111_2222, 4'h3);
    set_mem(1'b1, 1'b1, 32'hFF);
    #1;
    checks++;
    if ({mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ibus_ready, ibus_rvalid, ibus_rdata,
         dbus_ready, dbus_rvalid, dbus_rdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b addr=%h drv=%b drd=%h iready=%b dready=%b, want all 0",
               mem_valid, mem_addr, dbus_rvalid, dbus_rdata, ibus_ready, dbus_ready);
    end
    next_cycle();
    checks++;
    if ({dbg_owner, dbg_lock, dbg_last_grant} !== 6'b00_00_10) begin
      errors++;
      $display("FAIL mid_reset_state: got owner=%0d lock=%0d last=%0d, want 0 0 2",
               dbg_owner, dbg_lock, dbg_last_grant);
    end
    rst = 1'b0;
    set_ibus(1'b0, '0);
    set_dbus(1'b0, '0, 1'b0, '0, '0);
    set_mem(1'b1, 1'b1, 32'hEE);
    #1;
    checks++;
    if ({ibus_rvalid, dbus_rvalid, dbg_stray} !== 3'b001) begin
      errors++;
      $display("FAIL mid_late_rvalid: got irv=%b drv=%b stray=%b, want 0 0 1", ibus_rvalid, dbus_rvalid, dbg_stray);
    end
    next_cycle();
    set_ibus(1'b1, 32'h0000_0600);
    set_dbus(1'b1, 32'h0000_0700, 1'b0, '0, '0);
    set_mem(1'b1, 1'b0, '0);
    #1;
    checks++;
    if ({mem_valid, mem_addr, ibus_ready, dbus_ready} !== {1'b1, 32'h600, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_first_grant: got valid=%b addr=%h iready=%b dready=%b, want 1 00000600 1 0",
               mem_valid, mem_addr, ibus_ready, dbus_ready);
    end
    next_cycle();
    set_ibus(1'b0, '0);
    set_dbus(1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_stall_and_back_to_back();
    test_stray();
    test_reset_mid();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
